// File: rtl/cpu_sequencer.sv
// Control sequencer for the 8-bit accumulator processor: steps fetch/decode/execute over the
// shared datapath and drives one-hot strobes combinationally from state, opcode and handshakes.
module cpu_sequencer #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned OP_W   = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            mem_ready,
  input  logic            run,
  input  logic            step,
  output logic            pc_to_bus,
  output logic            addr_to_bus,
  output logic            mdr_to_bus,
  output logic            acc_to_bus,
  output logic            sw_to_bus,
  output logic            load_pc,
  output logic            inc_pc,
  output logic            load_mar,
  output logic            load_mdr,
  output logic            load_ir,
  output logic            load_acc,
  output logic            load_out,
  output logic            cs,
  output logic            r_nw,
  output logic [1:0]      alu_op,
  output logic            halted,
  output logic            instr_done
);

  localparam logic [WORD_W-1:0] OpLoad  = WORD_W'(0);
  localparam logic [WORD_W-1:0] OpStore = WORD_W'(1);
  localparam logic [WORD_W-1:0] OpAdd   = WORD_W'(2);
  localparam logic [WORD_W-1:0] OpSub   = WORD_W'(3);
  localparam logic [WORD_W-1:0] OpBne   = WORD_W'(4);
  localparam logic [WORD_W-1:0] OpIn    = WORD_W'(5);
  localparam logic [WORD_W-1:0] OpOut   = WORD_W'(6);
  localparam logic [WORD_W-1:0] OpHalt  = WORD_W'(7);

  typedef enum logic [3:0] {
    StFetch,
    StIread,
    StDecode,
    StAddr,
    StDread,
    StExec,
    StDwrite,
    StPause,
    StHalt
  } state_e;

  state_e            state_q, state_d, state_next;
  logic [WORD_W-1:0] opcode;

  // Wider opcode fields decode anything above HALT as a NOP.
  assign opcode     = WORD_W'(op);
  assign state_next = run ? StFetch : StPause;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_to_bus   = 1'b0;
    addr_to_bus = 1'b0;
    mdr_to_bus  = 1'b0;
    acc_to_bus  = 1'b0;
    sw_to_bus   = 1'b0;
    load_pc     = 1'b0;
    inc_pc      = 1'b0;
    load_mar    = 1'b0;
    load_mdr    = 1'b0;
    load_ir     = 1'b0;
    load_acc    = 1'b0;
    load_out    = 1'b0;
    cs          = 1'b0;
    r_nw        = 1'b1;
    alu_op      = 2'b00;
    halted      = 1'b0;
    instr_done  = 1'b0;

    unique case (state_q)
      StFetch: begin
        pc_to_bus = 1'b1;
        load_mar  = 1'b1;
        inc_pc    = 1'b1;
        state_d   = StIread;
      end
      StIread: begin
        cs       = 1'b1;
        load_mdr = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        mdr_to_bus = 1'b1;
        load_ir    = 1'b1;
        state_d    = StAddr;
      end
      StAddr: begin
        case (opcode)
          OpLoad, OpAdd, OpSub: begin
            addr_to_bus = 1'b1;
            load_mar    = 1'b1;
            state_d     = StDread;
          end
          OpStore: begin
            addr_to_bus = 1'b1;
            load_mar    = 1'b1;
            state_d     = StDwrite;
          end
          OpBne: begin
            addr_to_bus = !z_flag;
            load_pc     = !z_flag;
            instr_done  = 1'b1;
            state_d     = state_next;
          end
          OpIn: begin
            sw_to_bus  = 1'b1;
            load_acc   = 1'b1;
            instr_done = 1'b1;
            state_d    = state_next;
          end
          OpOut: begin
            acc_to_bus = 1'b1;
            load_out   = 1'b1;
            instr_done = 1'b1;
            state_d    = state_next;
          end
          OpHalt: state_d = StHalt;
          default: begin
            instr_done = 1'b1;
            state_d    = state_next;
          end
        endcase
      end
      StDread: begin
        cs       = 1'b1;
        load_mdr = mem_ready;
        if (mem_ready) state_d = StExec;
      end
      StExec: begin
        mdr_to_bus = 1'b1;
        load_acc   = 1'b1;
        if (opcode == OpAdd) begin
          alu_op = 2'b01;
        end else if (opcode == OpSub) begin
          alu_op = 2'b10;
        end
        instr_done = 1'b1;
        state_d    = state_next;
      end
      StDwrite: begin
        // Bus, select and direction stay put across wait states.
        acc_to_bus = 1'b1;
        cs         = 1'b1;
        r_nw       = 1'b0;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = state_next;
        end
      end
      StPause: begin
        if (run || step) state_d = StFetch;
      end
      StHalt: halted = 1'b1;
      default: state_d = StFetch;
    endcase

    // Reset kills every strobe immediately so an in-flight write cannot land.
    if (reset) begin
      pc_to_bus   = 1'b0;
      addr_to_bus = 1'b0;
      mdr_to_bus  = 1'b0;
      acc_to_bus  = 1'b0;
      sw_to_bus   = 1'b0;
      load_pc     = 1'b0;
      inc_pc      = 1'b0;
      load_mar    = 1'b0;
      load_mdr    = 1'b0;
      load_ir     = 1'b0;
      load_acc    = 1'b0;
      load_out    = 1'b0;
      cs          = 1'b0;
      r_nw        = 1'b1;
      alu_op      = 2'b00;
      halted      = 1'b0;
      instr_done  = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a small datapath/memory driven by the strobes, directed scenarios,
// and a random program checked against an instruction-level model.
module tb_cpu_sequencer;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned OP_W   = 3;

  // Output vector bit positions, MSB first in port order.
  localparam logic [17:0] PB = 18'h20000, AB = 18'h10000, MB = 18'h08000, CB = 18'h04000;
  localparam logic [17:0] SB = 18'h02000, LPC = 18'h01000, IPC = 18'h00800, LMAR = 18'h00400;
  localparam logic [17:0] LMDR = 18'h00200, LIR = 18'h00100, LACC = 18'h00080;
  localparam logic [17:0] LOUT = 18'h00040, CSB = 18'h00020, RNW = 18'h00010;
  localparam logic [17:0] ADDB = 18'h00004, SUBB = 18'h00008, HLT = 18'h00002, DONE = 18'h00001;

  localparam logic [17:0] VFETCH  = PB | IPC | LMAR | RNW;
  localparam logic [17:0] VRDWAIT = CSB | RNW;
  localparam logic [17:0] VRD     = CSB | RNW | LMDR;
  localparam logic [17:0] VDEC    = MB | LIR | RNW;
  localparam logic [17:0] VAMEM   = AB | LMAR | RNW;
  localparam logic [17:0] VEXEC   = MB | LACC | RNW | DONE;
  localparam logic [17:0] VWRWAIT = CB | CSB;
  localparam logic [17:0] VWR     = CB | CSB | DONE;
  localparam logic [17:0] VIDLE   = RNW;
  localparam logic [17:0] VHALT   = HLT | RNW;
  localparam logic [17:0] VIN     = SB | LACC | RNW | DONE;
  localparam logic [17:0] VOUT    = CB | LOUT | RNW | DONE;
  localparam logic [17:0] VBNE_T  = AB | LPC | RNW | DONE;
  localparam logic [17:0] VBNE_N  = RNW | DONE;

  logic clock = 1'b0, reset = 1'b1, mem_ready = 1'b1, run = 1'b1, step = 1'b0;
  logic [OP_W-1:0] op;
  logic z_flag;
  logic pc_to_bus, addr_to_bus, mdr_to_bus, acc_to_bus, sw_to_bus;
  logic load_pc, inc_pc, load_mar, load_mdr, load_ir, load_acc, load_out, cs, r_nw;
  logic [1:0] alu_op;
  logic halted, instr_done;
  logic [17:0] vec;

  logic [7:0] mem [32];
  logic [7:0] prog [32];
  logic [4:0] pc, mar;
  logic [7:0] mdr, ir, acc, outr, bus;
  logic [7:0] sw = 8'h00;
  logic reload = 1'b1;

  int checks = 0, errors = 0, wait_pct = 0, waits = 0, conflicts = 0;
  bit plan [$];
  logic [17:0] trace [$];

  logic [7:0] gmem [32];
  logic [4:0] gpc;
  logic [7:0] gacc, gout;

  cpu_sequencer #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
    .clock(clock), .reset(reset), .op(op), .z_flag(z_flag), .mem_ready(mem_ready),
    .run(run), .step(step), .pc_to_bus(pc_to_bus), .addr_to_bus(addr_to_bus),
    .mdr_to_bus(mdr_to_bus), .acc_to_bus(acc_to_bus), .sw_to_bus(sw_to_bus),
    .load_pc(load_pc), .inc_pc(inc_pc), .load_mar(load_mar), .load_mdr(load_mdr),
    .load_ir(load_ir), .load_acc(load_acc), .load_out(load_out), .cs(cs), .r_nw(r_nw),
    .alu_op(alu_op), .halted(halted), .instr_done(instr_done)
  );

  always #5 clock = ~clock;

  assign vec = {pc_to_bus, addr_to_bus, mdr_to_bus, acc_to_bus, sw_to_bus, load_pc, inc_pc,
                load_mar, load_mdr, load_ir, load_acc, load_out, cs, r_nw, alu_op, halted,
                instr_done};
  assign op     = ir[7:5];
  assign z_flag = (acc == 8'h00);

  always_comb begin
    bus = 8'h00;
    if (pc_to_bus)   bus = {3'b000, pc};
    if (addr_to_bus) bus = {3'b000, ir[4:0]};
    if (mdr_to_bus)  bus = mdr;
    if (acc_to_bus)  bus = acc;
    if (sw_to_bus)   bus = sw;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= '0; mar <= '0; mdr <= '0; ir <= '0; acc <= '0; outr <= '0;
      if (reload) for (int i = 0; i < 32; i++) mem[i] <= prog[i];
    end else begin
      if (load_pc) pc <= bus[4:0];
      else if (inc_pc) pc <= pc + 5'd1;
      if (load_mar) mar <= bus[4:0];
      if (load_mdr) mdr <= mem[mar];
      if (load_ir) ir <= bus;
      if (load_acc) begin
        case (alu_op)
          2'b01:   acc <= acc + bus;
          2'b10:   acc <= acc - bus;
          default: acc <= bus;
        endcase
      end
      if (load_out) outr <= bus;
      if (cs && !r_nw && mem_ready) mem[mar] <= bus;
    end
  end

  task automatic cycle();
    @(negedge clock);
    if (plan.size() > 0) mem_ready = plan.pop_front();
    else mem_ready = ($urandom_range(99) >= wait_pct);
    #1;
  endtask

  task automatic commit();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic rl);
    reload = rl;
    reset  = 1'b1;
    plan.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic fill_prog(input logic [7:0] v);
    for (int i = 0; i < 32; i++) prog[i] = v;
  endtask

  task automatic run_instr();
    int n;
    n = 0; waits = 0; conflicts = 0;
    trace.delete();
    do begin
      cycle();
      trace.push_back(vec);
      if (cs && !mem_ready) waits++;
      if ($countones(vec[17:13]) > 1) conflicts++;
      n++;
    end while (!instr_done && n < 100);
    checks++;
    if (instr_done !== 1'b1) begin
      errors++;
      $display("FAIL instr_timeout got instr_done=%b want 1 within 100 cycles", instr_done);
    end
  endtask

  task automatic test_reset();
    fill_prog(8'hE0);
    reload = 1'b1; run = 1'b1; step = 1'b0; wait_pct = 0; reset = 1'b1;
    repeat (3) begin
      @(negedge clock); #1;
      checks++;
      if (vec !== VIDLE) begin
        errors++; $display("FAIL reset_outputs got %h want %h", vec, VIDLE);
      end
    end
    @(posedge clock); #1 reset = 1'b0;
    cycle();
    checks++;
    if (vec !== VFETCH) begin errors++; $display("FAIL first_fetch got %h want %h", vec, VFETCH); end
    cycle();
    checks++;
    if (vec !== VRD) begin errors++; $display("FAIL first_iread got %h want %h", vec, VRD); end
  endtask

  task automatic test_load();
    logic [17:0] exp [6];
    exp = '{VFETCH, VRD, VDEC, VAMEM, VRD, VEXEC};
    fill_prog(8'hE0);
    prog[0] = 8'h02; prog[2] = 8'h15;
    run = 1'b1; wait_pct = 0;
    do_reset(1'b1);
    run_instr();
    checks++;
    if (trace.size() != 6) begin
      errors++; $display("FAIL load_cycles got %0d want 6", trace.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < trace.size()) begin
        checks++;
        if (trace[i] !== exp[i]) begin
          errors++; $display("FAIL load_cycle%0d got %h want %h", i, trace[i], exp[i]);
        end
      end
    end
    commit();
    checks++;
    if (acc !== 8'h15) begin errors++; $display("FAIL load_acc got %h want 15", acc); end
  endtask

  task automatic test_alu_store();
    int writes;
    fill_prog(8'hE0);
    prog[0] = 8'h10; prog[1] = 8'h51; prog[2] = 8'h72; prog[3] = 8'h33;
    prog[16] = 8'h15; prog[17] = 8'h20; prog[18] = 8'h07; prog[19] = 8'h00;
    run = 1'b1; wait_pct = 0;
    do_reset(1'b1);
    run_instr(); commit();
    run_instr();
    checks++;
    if (trace[5] !== (VEXEC | ADDB)) begin
      errors++; $display("FAIL add_exec got %h want %h", trace[5], VEXEC | ADDB);
    end
    commit();
    checks++;
    if (acc !== 8'h35) begin errors++; $display("FAIL add_acc got %h want 35", acc); end
    run_instr();
    checks++;
    if (trace[5] !== (VEXEC | SUBB)) begin
      errors++; $display("FAIL sub_exec got %h want %h", trace[5], VEXEC | SUBB);
    end
    commit();
    checks++;
    if (acc !== 8'h2E) begin errors++; $display("FAIL sub_acc got %h want 2e", acc); end
    run_instr();
    writes = 0;
    foreach (trace[i]) if (trace[i][4] == 1'b0) writes++;
    checks++;
    if (trace.size() != 5) begin
      errors++; $display("FAIL store_cycles got %0d want 5", trace.size());
    end
    checks++;
    if (trace[4] !== VWR || writes != 1) begin
      errors++; $display("FAIL store_dwrite got %h/%0d want %h/1", trace[4], writes, VWR);
    end
    commit();
    checks++;
    if (mem[19] !== 8'h2E) begin errors++; $display("FAIL store_mem got %h want 2e", mem[19]); end
  endtask

  task automatic test_wait_states();
    logic [17:0] exp [10];
    exp = '{VFETCH, VRDWAIT, VRDWAIT, VRDWAIT, VRD, VDEC, VAMEM, VWRWAIT, VWRWAIT, VWR};
    fill_prog(8'hE0);
    prog[0] = 8'hA0; prog[1] = 8'h34;
    sw = 8'h5A; run = 1'b1; wait_pct = 0;
    do_reset(1'b1);
    run_instr(); commit();
    plan = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    run_instr();
    checks++;
    if (trace.size() != 10 || waits != 5) begin
      errors++; $display("FAIL wait_cycles got %0d/%0d want 10/5", trace.size(), waits);
    end
    for (int i = 0; i < 10; i++) begin
      if (i < trace.size()) begin
        checks++;
        if (trace[i] !== exp[i]) begin
          errors++; $display("FAIL wait_cycle%0d got %h want %h", i, trace[i], exp[i]);
        end
      end
    end
    commit();
    checks++;
    if (mem[20] !== 8'h5A) begin errors++; $display("FAIL wait_mem got %h want 5a", mem[20]); end
  endtask

  task automatic test_branch_io();
    fill_prog(8'hE0);
    prog[0] = 8'h85; prog[1] = 8'hA0; prog[2] = 8'hC0; prog[3] = 8'h89;
    sw = 8'h3C; run = 1'b1; wait_pct = 0;
    do_reset(1'b1);
    run_instr();
    checks++;
    if (trace.size() != 4 || trace[3] !== VBNE_N) begin
      errors++; $display("FAIL bne_z got %h want %h", trace[3], VBNE_N);
    end
    commit();
    checks++;
    if (pc !== 5'd1) begin errors++; $display("FAIL bne_z_pc got %0d want 1", pc); end
    run_instr();
    checks++;
    if (trace[3] !== VIN) begin errors++; $display("FAIL in_addr got %h want %h", trace[3], VIN); end
    commit();
    checks++;
    if (acc !== 8'h3C) begin errors++; $display("FAIL in_acc got %h want 3c", acc); end
    run_instr();
    checks++;
    if (trace[3] !== VOUT) begin
      errors++; $display("FAIL out_addr got %h want %h", trace[3], VOUT);
    end
    commit();
    checks++;
    if (outr !== 8'h3C) begin errors++; $display("FAIL out_reg got %h want 3c", outr); end
    run_instr();
    checks++;
    if (trace[3] !== VBNE_T) begin
      errors++; $display("FAIL bne_nz got %h want %h", trace[3], VBNE_T);
    end
    commit();
    checks++;
    if (pc !== 5'd9) begin errors++; $display("FAIL bne_nz_pc got %0d want 9", pc); end
  endtask

  task automatic test_pause_step();
    int busy, dones;
    fill_prog(8'hA0);
    sw = 8'h11; run = 1'b0; wait_pct = 0;
    do_reset(1'b1);
    run_instr();
    checks++;
    if (trace.size() != 4) begin
      errors++; $display("FAIL pause_first got %0d cycles want 4", trace.size());
    end
    busy = 0;
    repeat (5) begin cycle(); if (vec !== VIDLE) busy++; end
    checks++;
    if (busy != 0) begin errors++; $display("FAIL pause_idle got %0d active want 0", busy); end
    dones = 0;
    repeat (2) begin
      step = 1'b1; cycle(); step = 1'b0;
      repeat (15) begin cycle(); if (instr_done) dones++; end
    end
    checks++;
    if (dones != 2) begin errors++; $display("FAIL step_count got %0d want 2", dones); end
    checks++;
    if (vec !== VIDLE) begin errors++; $display("FAIL step_repause got %h want %h", vec, VIDLE); end
    run = 1'b1;
    cycle();
    checks++;
    if (vec !== VFETCH) begin errors++; $display("FAIL pause_run got %h want %h", vec, VFETCH); end
  endtask

  task automatic test_halt();
    int n, bad;
    fill_prog(8'hE0);
    prog[0] = 8'hA0;
    run = 1'b1; wait_pct = 0;
    do_reset(1'b1);
    run_instr();
    n = 0;
    do begin cycle(); n++; end while (!halted && n < 10);
    checks++;
    if (n != 5) begin errors++; $display("FAIL halt_latency got %0d want 5", n); end
    checks++;
    if (vec !== VHALT) begin errors++; $display("FAIL halt_outputs got %h want %h", vec, VHALT); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step = (i % 2 == 0); run = (i % 2 != 0);
      cycle();
      if (vec !== VHALT) bad++;
    end
    step = 1'b0; run = 1'b1;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL halt_sticky got %0d exits want 0", bad); end
    reset = 1'b1; #1;
    checks++;
    if (vec !== VIDLE) begin errors++; $display("FAIL halt_reset got %h want %h", vec, VIDLE); end
    do_reset(1'b1);
    cycle();
    checks++;
    if (vec !== VFETCH) begin errors++; $display("FAIL halt_refetch got %h want %h", vec, VFETCH); end
  endtask

  task automatic test_reset_abort();
    fill_prog(8'hE0);
    prog[0] = 8'hA0; prog[1] = 8'h10; prog[2] = 8'h31; prog[16] = 8'h44; prog[17] = 8'h99;
    sw = 8'h33; run = 1'b1; wait_pct = 0;
    do_reset(1'b1);
    run_instr();
    plan = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    repeat (5) cycle();
    checks++;
    if (vec !== VRDWAIT) begin errors++; $display("FAIL abort_dread got %h want %h", vec, VRDWAIT); end
    reload = 1'b0; reset = 1'b1; #1;
    checks++;
    if (vec !== VIDLE) begin errors++; $display("FAIL abort_rd_out got %h want %h", vec, VIDLE); end
    do_reset(1'b0);
    cycle();
    checks++;
    if (vec !== VFETCH) begin errors++; $display("FAIL abort_refetch got %h want %h", vec, VFETCH); end
    run_instr(); commit();
    run_instr(); commit();
    checks++;
    if (acc !== 8'h44) begin errors++; $display("FAIL abort_reload got %h want 44", acc); end
    plan = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    repeat (5) cycle();
    checks++;
    if (vec !== VWR) begin errors++; $display("FAIL abort_dwrite got %h want %h", vec, VWR); end
    reload = 1'b0; reset = 1'b1; #1;
    checks++;
    if (vec !== VIDLE) begin errors++; $display("FAIL abort_wr_out got %h want %h", vec, VIDLE); end
    commit();
    checks++;
    if (mem[17] !== 8'h99) begin errors++; $display("FAIL abort_no_write got %h want 99", mem[17]); end
    do_reset(1'b1);
  endtask

  task automatic test_random();
    logic [7:0] ins;
    logic [2:0] gop;
    logic [4:0] ga;
    int base;
    for (int i = 0; i < 32; i++) begin
      prog[i] = 8'($urandom_range(255));
      if (prog[i][7:5] == 3'b111) prog[i][7:5] = 3'b110;
    end
    sw = 8'($urandom_range(255)); run = 1'b1; wait_pct = 30;
    do_reset(1'b1);
    for (int i = 0; i < 32; i++) gmem[i] = prog[i];
    gpc = '0; gacc = '0; gout = '0;
    for (int k = 0; k < 60; k++) begin
      ins = gmem[gpc]; gop = ins[7:5]; ga = ins[4:0];
      base = (gop == 3'd0 || gop == 3'd2 || gop == 3'd3) ? 6 : (gop == 3'd1) ? 5 : 4;
      run_instr();
      checks++;
      if (trace[0] !== VFETCH || conflicts != 0) begin
        errors++; $display("FAIL rnd_start%0d got %h/%0d want %h/0", k, trace[0], conflicts, VFETCH);
      end
      checks++;
      if (trace.size() != base + waits) begin
        errors++;
        $display("FAIL rnd_cycles%0d op%0d got %0d want %0d", k, gop, trace.size(), base + waits);
      end
      gpc = gpc + 5'd1;
      case (gop)
        3'd0: gacc = gmem[ga];
        3'd1: gmem[ga] = gacc;
        3'd2: gacc = gacc + gmem[ga];
        3'd3: gacc = gacc - gmem[ga];
        3'd4: if (gacc != 8'h00) gpc = ga;
        3'd5: gacc = sw;
        3'd6: gout = gacc;
        default: ;
      endcase
      commit();
      checks++;
      if ({pc, acc, outr} !== {gpc, gacc, gout}) begin
        errors++;
        $display("FAIL rnd_state%0d op%0d got pc=%0d acc=%h out=%h want pc=%0d acc=%h out=%h",
                 k, gop, pc, acc, outr, gpc, gacc, gout);
      end
      if (gop == 3'd1) begin
        checks++;
        if (mem[ga] !== gmem[ga]) begin
          errors++; $display("FAIL rnd_mem%0d got %h want %h", k, mem[ga], gmem[ga]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_alu_store();
    test_wait_states();
    test_branch_io();
    test_pause_step();
    test_halt();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Control unit for the 8-bit accumulator processor. It sequences fetch, decode and execute over the shared datapath: PC, MAR, MDR, IR, ACC, ALU and the single memory port. It drives one-hot datapath control strobes from an internal state machine and the IR opcode field. It supports memory wait states, run/single-step and a halt instruction.

## Interface
- WORD_W, 8, datapath word width (opcode + address field)
- OP_W, 3, opcode field width; address field is WORD_W-OP_W bits (datapath side)

- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- op  in  OP_W  IR opcode field, valid from the cycle after load_ir
- z_flag  in  1  1 when ACC == 0
- mem_ready  in  1  memory completes current cs access this cycle
- run  in  1  level: 1 = free-running, 0 = pause at instruction boundary
- step  in  1  in PAUSE, 1 = execute exactly one instruction
- pc_to_bus, addr_to_bus, mdr_to_bus, acc_to_bus, sw_to_bus  out  1 each  bus drivers (at most one high per cycle)
- load_pc, inc_pc, load_mar, load_mdr, load_ir, load_acc, load_out  out  1 each  register load strobes
- cs  out  1  memory select; r_nw  out  1  1 = read, 0 = write
- alu_op  out  2  00 pass bus, 01 ACC+bus, 10 ACC-bus (mod 2^WORD_W, datapath side)
- halted  out  1  high in HALT state
- instr_done  out  1  one-cycle pulse in the last cycle of every instruction

## Operation
- Opcodes: 0 LOAD, 1 STORE, 2 ADD, 3 SUB, 4 BNE (branch if ACC != 0), 5 IN (switches->ACC), 6 OUT (ACC->display register), 7 HALT; any op >= 8 (OP_W > 3) is a NOP.
- States: FETCH, IREAD, DECODE, ADDR, DREAD, EXEC, DWRITE, PAUSE, HALT.
- FETCH: pc_to_bus, load_mar, inc_pc -> IREAD.
- IREAD: cs, r_nw=1; load_mdr = mem_ready; stay while !mem_ready, else -> DECODE.
- DECODE: mdr_to_bus, load_ir -> ADDR.
- ADDR, by op:
  - LOAD/ADD/SUB: addr_to_bus, load_mar -> DREAD.
  - STORE: addr_to_bus, load_mar -> DWRITE.
  - BNE: if !z_flag, addr_to_bus, load_pc; instr_done -> NEXT.
  - IN: sw_to_bus, load_acc, alu_op=00; instr_done -> NEXT.
  - OUT: acc_to_bus, load_out; instr_done -> NEXT.
  - HALT -> HALT. NOP: instr_done -> NEXT.
- DREAD: cs, r_nw=1; load_mdr = mem_ready; wait until mem_ready -> EXEC.
- EXEC: mdr_to_bus, load_acc, alu_op = 00/01/10 for LOAD/ADD/SUB; instr_done -> NEXT.
- DWRITE: acc_to_bus, cs, r_nw=0 held stable; instr_done on the mem_ready cycle -> NEXT; wait while !mem_ready.
- NEXT = FETCH if run, else PAUSE.
- PAUSE: all strobes 0; run or step -> FETCH. A step pulse runs one instruction, then returns to PAUSE if run=0. step is ignored outside PAUSE.
- HALT: halted=1, all strobes 0; only reset exits.
- Outputs are combinational from state, op, z_flag and mem_ready. r_nw is 1 whenever not in DWRITE.

## Timing
- Reset: state <= FETCH asynchronously. While reset=1, all outputs are forced 0, including halted and instr_done, with r_nw=1. The first FETCH strobes appear in the cycle reset is low.
- Reset mid-instruction (any state, including wait states and HALT) aborts immediately. No partial write completes after reset is asserted.
- Zero-wait latency, FETCH to instr_done inclusive: LOAD/ADD/SUB 6 cycles, STORE 5, BNE/IN/OUT/NOP 4. Each cycle with mem_ready=0 in IREAD/DREAD/DWRITE adds 1 cycle.
- mem_ready is sampled only while cs=1 and is ignored elsewhere.
- run is sampled only at NEXT decisions. Dropping run mid-instruction completes the instruction, then enters PAUSE.
- Simultaneous run=1 and step=1 in PAUSE: go to FETCH (free-running).
- op and z_flag are sampled only in ADDR and EXEC.

## Test plan
- Reset then run=1, mem_ready=1, instruction 0x02 (LOAD 2) with mem[2]=0x15 -> strobe sequence FETCH..EXEC over 6 cycles, load_acc with alu_op=00 in cycle 6, instr_done once.
- ADD then SUB (op 2, 3) -> alu_op=01 then 10 in the EXEC cycles. STORE -> cs=1, r_nw=0, acc_to_bus in DWRITE only, 5-cycle instruction.
- mem_ready held low for 3 cycles in IREAD and 2 in DWRITE -> state holds with strobes stable, and the STORE completes in 5+2 cycles after a 3-cycle IREAD stretch (total per design cycles checked).
- BNE with z_flag=1 -> no load_pc. BNE with z_flag=0 -> load_pc and addr_to_bus in ADDR. IN/OUT -> sw_to_bus+load_acc and acc_to_bus+load_out respectively.
- run=0 from reset -> PAUSE after the first instruction. Two step pulses -> exactly two more instr_done pulses. Opcode 7 -> halted=1, stays halted despite step/run until reset.
- Assert reset during DREAD and during DWRITE -> all outputs 0 within the same cycle, and the next instruction after release starts at FETCH.
